// File: rtl/fpu_sched_pkg.sv
// ---------------------------------------------------------------------------
// fpu_sched_pkg
// Shared constants and helpers for the multi-cycle FP unit scheduler.
//   REG_IDX_W : width of a register index
//   LAT_W     : width of the unit latency and of the countdown
//   WB_DIST   : cycles from ID issue to WB for a single-cycle instruction
//   MIN_LAT   : smallest effective unit latency; shorter requests are clamped
// ---------------------------------------------------------------------------
package fpu_sched_pkg;

  localparam int REG_IDX_W = 5;
  localparam int LAT_W     = 5;
  localparam int WB_DIST   = 3;
  localparam int MIN_LAT   = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0]     lat_t;

  // Clamp a requested unit latency up to MIN_LAT.
  function automatic lat_t clamp_lat(input lat_t lat);
    lat_t min_v;
    min_v = lat_t'(MIN_LAT);
    if (lat < min_v) begin
      return min_v;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/fpu_mc_timer.sv
// ---------------------------------------------------------------------------
// fpu_mc_timer
// Loadable down-counter with a pending flag, tracking the single in-flight
// multi-cycle op. The cycle with pending set and cnt at zero is the
// completion cycle (done).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : start tracking a new op (allowed in the completion cycle)
//   load_val   : countdown start value (already clamped by the caller)
//   cancel     : drop the in-flight op and freeze the countdown
//   cnt        : remaining cycles before the completion cycle
//   pending    : an op is in flight
//   done       : completion cycle
// ---------------------------------------------------------------------------
module fpu_mc_timer
  import fpu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  lat_t       load_val,
  input  logic       cancel,
  output lat_t       cnt,
  output logic       pending,
  output logic       done
);

  lat_t cnt_r;
  logic pending_r;

  // Countdown and pending flag; cancel outranks load, load outranks countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {LAT_W{1'b0}};
      pending_r <= 1'b0;
    end else if (cancel) begin
      cnt_r     <= {LAT_W{1'b0}};
      pending_r <= 1'b0;
    end else if (load) begin
      cnt_r     <= load_val;
      pending_r <= 1'b1;
    end else if (pending_r) begin
      if (cnt_r != {LAT_W{1'b0}}) begin
        cnt_r <= cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
      end else begin
        // Completion cycle passed with no new op loaded.
        pending_r <= 1'b0;
      end
    end else begin
      cnt_r     <= cnt_r;
      pending_r <= pending_r;
    end
  end

  assign cnt     = cnt_r;
  assign pending = pending_r;
  assign done    = pending_r & (cnt_r == {LAT_W{1'b0}});

endmodule

// File: rtl/fpu_mc_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_mc_scheduler
// Issue/writeback scheduler for the single multi-cycle FP unit (fdiv/fsqrt)
// in the 5-stage pipeline. Tracks one in-flight op and stalls ID on RAW/WAW
// against it, on structural reuse of the unit and on FP writeback-port
// collisions. Drives start/abort/writeback strobes to the unit.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   id_valid, id_hold     : ID has an instruction / ID held elsewhere
//   id_rs1..3, id_rsN_f   : source indices and "read from FP file" flags
//   id_rd, id_f_regwrite  : destination and "writes FP file"
//   id_mc_op, id_mc_lat   : uses the multi-cycle unit, with its latency
//   ex_flush              : kill the instruction in EX
//   stall                 : combinational hold of IF/ID
//   busy                  : op in flight
//   mc_start, mc_abort    : one-cycle start / cancel pulses to the unit
//   mc_wb, mc_wb_rd       : FP write strobe for the unit result and its index
// Optional build macro FPU_MC_SCHED_STATS_EN adds:
//   stall_cnt             : saturating count of cycles with id_valid & stall
// ---------------------------------------------------------------------------
module fpu_mc_scheduler
  import fpu_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_hold,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rs3,
  input  logic                 id_rs1_f,
  input  logic                 id_rs2_f,
  input  logic                 id_rs3_f,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_f_regwrite,
  input  logic                 id_mc_op,
  input  logic [LAT_W-1:0]     id_mc_lat,
  input  logic                 ex_flush,
  output logic                 stall,
  output logic                 busy,
  output logic                 mc_start,
  output logic                 mc_abort,
  output logic                 mc_wb,
  output logic [REG_IDX_W-1:0] mc_wb_rd
`ifdef FPU_MC_SCHED_STATS_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  reg_idx_t pend_rd_r;
  logic     mc_start_r;
  logic     mc_abort_r;

  lat_t     cnt_s;
  logic     pending_s;
  logic     done_s;

  logic     cnt_nz_s;
  logic     raw_s;
  logic     waw_s;
  logic     struct_haz_s;
  logic     wb_coll_s;
  logic     stall_s;
  logic     issue_s;
  logic     mc_issue_s;
  logic     cancel_s;

  // Hazard terms and issue decode; stall depends only on state and ID fields.
  always_comb begin
    cnt_nz_s     = 1'b0;
    raw_s        = 1'b0;
    waw_s        = 1'b0;
    struct_haz_s = 1'b0;
    wb_coll_s    = 1'b0;
    stall_s      = 1'b0;
    issue_s      = 1'b0;
    mc_issue_s   = 1'b0;
    cancel_s     = 1'b0;

    cnt_nz_s     = (cnt_s != {LAT_W{1'b0}});
    // RAW stays active through the completion cycle: the result is written
    // in that cycle, so readers can only proceed on the following one.
    raw_s        = (id_rs1_f & (id_rs1 == pend_rd_r)) |
                   (id_rs2_f & (id_rs2 == pend_rd_r)) |
                   (id_rs3_f & (id_rs3 == pend_rd_r));
    waw_s        = id_f_regwrite & (id_rd == pend_rd_r) & cnt_nz_s;
    struct_haz_s = id_mc_op & cnt_nz_s;
    // A single-cycle FP writer issued now would reach WB together with mc_wb.
    wb_coll_s    = id_f_regwrite & ~id_mc_op & (cnt_s == lat_t'(WB_DIST));
    stall_s      = id_valid & pending_s &
                   (raw_s | waw_s | struct_haz_s | wb_coll_s);
    issue_s      = id_valid & ~id_hold & ~stall_s;
    mc_issue_s   = issue_s & id_mc_op;
    // Only the op sitting in EX (its start cycle) can be flushed.
    cancel_s     = ex_flush & mc_start_r;
  end

  fpu_mc_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (mc_issue_s),
    .load_val (clamp_lat(id_mc_lat)),
    .cancel   (cancel_s),
    .cnt      (cnt_s),
    .pending  (pending_s),
    .done     (done_s)
  );

  // Start/abort pulses and the captured destination of the in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_rd_r  <= {REG_IDX_W{1'b0}};
      mc_start_r <= 1'b0;
      mc_abort_r <= 1'b0;
    end else begin
      mc_start_r <= mc_issue_s;
      mc_abort_r <= cancel_s;
      if (mc_issue_s) begin
        pend_rd_r <= id_rd;
      end else begin
        pend_rd_r <= pend_rd_r;
      end
    end
  end

`ifdef FPU_MC_SCHED_STATS_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles in which a valid ID instruction is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (id_valid & stall_s & (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign stall    = stall_s;
  assign busy     = pending_s;
  assign mc_start = mc_start_r;
  assign mc_abort = mc_abort_r;
  assign mc_wb    = done_s;
  // Index is driven only alongside the strobe so the write port sees zeros
  // when idle.
  assign mc_wb_rd = done_s ? pend_rd_r : {REG_IDX_W{1'b0}};

endmodule

// File: tb/tb_fpu_mc_scheduler.sv
// Testbench for fpu_mc_scheduler: directed vector table, hand sequences for
// clamping / reset / f0, then random stimulus against a timeline model that
// tracks the in-flight op by absolute start and writeback cycle numbers.
module tb_fpu_mc_scheduler;

  localparam int M_MIN_LAT = 4;
  localparam int M_WB_DIST = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_hold;
  logic [4:0] id_rs1, id_rs2, id_rs3;
  logic       id_rs1_f, id_rs2_f, id_rs3_f;
  logic [4:0] id_rd;
  logic       id_f_regwrite, id_mc_op;
  logic [4:0] id_mc_lat;
  logic       ex_flush;
  logic       stall, busy, mc_start, mc_abort, mc_wb;
  logic [4:0] mc_wb_rd;
`ifdef FPU_MC_SCHED_STATS_EN
  logic [31:0] stall_cnt;
  int unsigned m_scnt = 0;
`endif

  always #5 clk = ~clk;

  fpu_mc_scheduler dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_hold(id_hold),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_rs1_f(id_rs1_f), .id_rs2_f(id_rs2_f), .id_rs3_f(id_rs3_f),
    .id_rd(id_rd), .id_f_regwrite(id_f_regwrite), .id_mc_op(id_mc_op),
    .id_mc_lat(id_mc_lat), .ex_flush(ex_flush),
    .stall(stall), .busy(busy), .mc_start(mc_start), .mc_abort(mc_abort),
    .mc_wb(mc_wb), .mc_wb_rd(mc_wb_rd)
`ifdef FPU_MC_SCHED_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic       valid, hold, rst, flush;
    logic [4:0] rs1, rs2, rs3;
    logic       rs1_f, rs2_f, rs3_f;
    logic [4:0] rd;
    logic       fw, mc;
    logic [4:0] lat;
    logic       e_stall, e_busy, e_start, e_wb, e_abort;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Timeline model of the in-flight op.
  bit have_op  = 1'b0;
  int op_rd    = 0;
  int op_start = 0;
  int op_wb    = 0;
  int abort_at = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic rs1_f,
                              input logic [4:0] rd, input logic fw, input logic mc,
                              input logic [4:0] lat, input logic fl,
                              input logic es, input logic eb, input logic esa,
                              input logic ew, input logic ea);
    vec_t t;
    t.valid = v;  t.hold = 1'b0; t.rst = 1'b0; t.flush = fl;
    t.rs1 = rs1;  t.rs2 = 5'd0;  t.rs3 = 5'd0;
    t.rs1_f = rs1_f; t.rs2_f = 1'b0; t.rs3_f = 1'b0;
    t.rd = rd; t.fw = fw | mc; t.mc = mc; t.lat = lat;
    t.e_stall = es; t.e_busy = eb; t.e_start = esa; t.e_wb = ew; t.e_abort = ea;
    return t;
  endfunction

  // One pipeline cycle: drive ID fields, check every output against the
  // timeline model, then advance the model by the events of this cycle.
  task automatic step(input vec_t v);
    bit active, e_stall, e_busy, e_start, e_wb, e_abort, raw, waw, st, wbc;
    int rem, eff;
    @(negedge clk);
    reset = v.rst; id_valid = v.valid; id_hold = v.hold; ex_flush = v.flush;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs3 = v.rs3;
    id_rs1_f = v.rs1_f; id_rs2_f = v.rs2_f; id_rs3_f = v.rs3_f;
    id_rd = v.rd; id_f_regwrite = v.fw; id_mc_op = v.mc; id_mc_lat = v.lat;
    #1;
    active  = have_op && (cyc >= op_start) && (cyc <= op_wb);
    rem     = op_wb - cyc;
    raw     = active && ((v.rs1_f && int'(v.rs1) == op_rd) ||
                         (v.rs2_f && int'(v.rs2) == op_rd) ||
                         (v.rs3_f && int'(v.rs3) == op_rd));
    waw     = active && v.fw && int'(v.rd) == op_rd && rem != 0;
    st      = active && v.mc && rem != 0;
    wbc     = active && v.fw && !v.mc && rem == M_WB_DIST;
    e_stall = v.valid && (raw || waw || st || wbc);
    e_busy  = active;
    e_start = active && cyc == op_start;
    e_wb    = active && cyc == op_wb;
    e_abort = (cyc == abort_at);
    chk("stall",    {31'd0, stall},    {31'd0, e_stall});
    chk("busy",     {31'd0, busy},     {31'd0, e_busy});
    chk("mc_start", {31'd0, mc_start}, {31'd0, e_start});
    chk("mc_wb",    {31'd0, mc_wb},    {31'd0, e_wb});
    chk("mc_abort", {31'd0, mc_abort}, {31'd0, e_abort});
    if (e_wb) chk("mc_wb_rd", {27'd0, mc_wb_rd}, op_rd);
`ifdef FPU_MC_SCHED_STATS_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    if (v.rst) m_scnt = 0;
    else if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
`endif
    if (v.rst) begin
      have_op  = 1'b0;
      abort_at = -1;
    end else begin
      if (v.flush && active && cyc == op_start) begin
        have_op  = 1'b0;
        abort_at = cyc + 1;
      end
      if (v.valid && !v.hold && !e_stall && v.mc) begin
        eff      = (int'(v.lat) < M_MIN_LAT) ? M_MIN_LAT : int'(v.lat);
        have_op  = 1'b1;
        op_rd    = int'(v.rd);
        op_start = cyc + 1;
        op_wb    = cyc + 1 + eff;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vec_t v;
    int t0;

    reset = 1'b1; id_valid = 1'b0; id_hold = 1'b0; ex_flush = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs3 = 5'd0;
    id_rs1_f = 1'b0; id_rs2_f = 1'b0; id_rs3_f = 1'b0;
    id_rd = 5'd0; id_f_regwrite = 1'b0; id_mc_op = 1'b0; id_mc_lat = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_mc_start", {31'd0, mc_start}, 32'd0);
    chk("rst_mc_abort", {31'd0, mc_abort}, 32'd0);
    chk("rst_mc_wb",    {31'd0, mc_wb},    32'd0);
    chk("rst_mc_wb_rd", {27'd0, mc_wb_rd}, 32'd0);

    //          v rs1 f  rd fw mc lat fl | st bu sa wb ab
    // fdiv f5 lat 8, then an fadd reading f5 held until after completion.
    tbl.push_back(mk(1, 0, 0, 5, 1, 1, 8, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, 7, 1, 0, 0, 0,  1, 1, 1, 0, 0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1, 5, 1, 7, 1, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, 7, 1, 0, 0, 0,  1, 1, 0, 1, 0));
    tbl.push_back(mk(1, 5, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    // fdiv f5 lat 8: f6 reader free, WAW, WB collision at cnt 3,
    // structural hold of fsqrt until completion, then flush of the fsqrt.
    tbl.push_back(mk(1, 0, 0, 5, 1, 1, 8, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6, 1, 9, 1, 0, 0, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6, 1, 10, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11, 1, 1, 4, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 11, 1, 1, 4, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk("tbl_stall",    {31'd0, stall},    {31'd0, tbl[i].e_stall});
      chk("tbl_busy",     {31'd0, busy},     {31'd0, tbl[i].e_busy});
      chk("tbl_mc_start", {31'd0, mc_start}, {31'd0, tbl[i].e_start});
      chk("tbl_mc_wb",    {31'd0, mc_wb},    {31'd0, tbl[i].e_wb});
      chk("tbl_mc_abort", {31'd0, mc_abort}, {31'd0, tbl[i].e_abort});
      if (tbl[i].e_wb) chk("tbl_mc_wb_rd", {27'd0, mc_wb_rd}, 32'd5);
    end

    // Latency 2 clamps to 4: writeback five cycles after issue.
    step(mk(1, 0, 0, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("clamp_no_wb", {31'd0, mc_wb}, 32'd0);
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("clamp_wb",    {31'd0, mc_wb},    32'd1);
    chk("clamp_wb_rd", {27'd0, mc_wb_rd}, 32'd3);
    idle(1);
    chk("clamp_idle", {31'd0, busy}, 32'd0);

    // Reset four cycles into a latency-8 op discards it with no strobes.
    step(mk(1, 0, 0, 4, 1, 1, 8, 0, 0, 0, 0, 0, 0));
    idle(3);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    step(v);
    idle(1);
    chk("rstop_busy",  {31'd0, busy},     32'd0);
    chk("rstop_wb",    {31'd0, mc_wb},    32'd0);
    chk("rstop_abort", {31'd0, mc_abort}, 32'd0);
    chk("rstop_start", {31'd0, mc_start}, 32'd0);
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      t0 = t0 | int'(mc_wb);
    end
    chk("rstop_never_wb", t0, 32'd0);

    // f0 is an ordinary FP register; integer x0 sources never match.
    step(mk(1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0));
    v = mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rs2 = 5'd0; v.rs2_f = 1'b0; v.rs3 = 5'd0; v.rs3_f = 1'b0;
    step(v);
    chk("f0_int_src", {31'd0, stall}, 32'd0);
    v.rs3_f = 1'b1;
    step(v);
    chk("f0_fp_src", {31'd0, stall}, 32'd1);
    idle(6);

    // Random traffic against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      v.valid = ($urandom_range(0, 3) != 0);
      v.hold  = ($urandom_range(0, 7) == 0);
      v.rst   = ($urandom_range(0, 149) == 0);
      v.flush = ($urandom_range(0, 5) == 0);
      v.rs1 = 5'($urandom_range(0, 7)); v.rs1_f = 1'($urandom_range(0, 1));
      v.rs2 = 5'($urandom_range(0, 7)); v.rs2_f = 1'($urandom_range(0, 1));
      v.rs3 = 5'($urandom_range(0, 7)); v.rs3_f = ($urandom_range(0, 3) == 0);
      v.rd  = 5'($urandom_range(0, 7));
      v.mc  = ($urandom_range(0, 3) == 0);
      v.fw  = v.mc | 1'($urandom_range(0, 1));
      v.lat = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                          : 5'($urandom_range(0, 10));
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
